// File: rtl/mitll_andn_sync.sv
// Clocked N-input RSFQ gate model: toggle-encoded data and clock pulses, selectable
// gate function, per-input stored-flux flags, double-pulse error flag and fire counter.
module mitll_andn_sync #(
    parameter int unsigned N  = 2,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  in_tgl,
    input  logic          ck_tgl,
    input  logic [1:0]    mode,
    input  logic          err_clr,
    output logic          out_tgl,
    output logic          out_pulse,
    output logic [N-1:0]  stored,
    output logic [CW-1:0] fire_cnt,
    output logic          err_double
);

    localparam int unsigned CNTW = $clog2(N + 1);

    typedef enum logic [1:0] {
        MODE_AND = 2'b00,
        MODE_OR  = 2'b01,
        MODE_XOR = 2'b10,
        MODE_MAJ = 2'b11
    } gate_mode_e;

    logic [N-1:0]    in_prev_q;
    logic            ck_prev_q;
    logic [N-1:0]    stored_q,   stored_d;
    logic            out_tgl_q,  out_tgl_d;
    logic            out_pulse_q, out_pulse_d;
    logic [CW-1:0]   fire_cnt_q, fire_cnt_d;
    logic            err_q,      err_d;

    logic [N-1:0]    in_p_c;
    logic            ck_p_c;
    logic [CNTW-1:0] cnt_c;
    logic            eval_c;
    logic            fire_c;

    // Pulse detection, gate evaluation on pre-edge flags, and next-state update
    always_comb begin
        in_p_c = in_tgl ^ in_prev_q;
        ck_p_c = ck_tgl ^ ck_prev_q;

        cnt_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            cnt_c = cnt_c + CNTW'(stored_q[i]);
        end

        case (mode)
            MODE_AND: eval_c = (cnt_c == CNTW'(N));
            MODE_OR:  eval_c = (cnt_c != '0);
            MODE_XOR: eval_c = cnt_c[0];
            default:  eval_c = (cnt_c > CNTW'(N / 2));
        endcase

        fire_c = ck_p_c & eval_c;

        // A pulse coincident with the gate clock survives the clear for the next evaluation
        stored_d = ck_p_c ? in_p_c : (stored_q | in_p_c);

        err_d = err_clr ? 1'b0 : (err_q | (~ck_p_c & (|(in_p_c & stored_q))));

        out_tgl_d   = out_tgl_q ^ fire_c;
        out_pulse_d = fire_c;
        fire_cnt_d  = fire_cnt_q + CW'(fire_c);
    end

    // State registers; previous-level registers track the inputs even in reset
    always_ff @(posedge clk) begin
        in_prev_q <= in_tgl;
        ck_prev_q <= ck_tgl;
        if (!rst_n) begin
            stored_q    <= '0;
            out_tgl_q   <= 1'b0;
            out_pulse_q <= 1'b0;
            fire_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            stored_q    <= stored_d;
            out_tgl_q   <= out_tgl_d;
            out_pulse_q <= out_pulse_d;
            fire_cnt_q  <= fire_cnt_d;
            err_q       <= err_d;
        end
    end

    assign out_tgl    = out_tgl_q;
    assign out_pulse  = out_pulse_q;
    assign stored     = stored_q;
    assign fire_cnt   = fire_cnt_q;
    assign err_double = err_q;

endmodule

// File: tb/tb_mitll_andn_sync.sv
// Bench for mitll_andn_sync: an N=2/CW=2 and an N=3/CW=8 instance share one stimulus
// stream and are both checked every cycle against a pulse-level reference model.
module tb_mitll_andn_sync;

    logic       clk;
    logic       rst_n;
    logic [2:0] in_tgl;
    logic       ck_tgl;
    logic [1:0] mode;
    logic       err_clr;

    logic       a_out, a_pulse, a_err;
    logic [1:0] a_st;
    logic [1:0] a_cnt;
    logic       b_out, b_pulse, b_err;
    logic [2:0] b_st;
    logic [7:0] b_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state, index 0 = N=2/CW=2, index 1 = N=3/CW=8
    int m_st[2], m_out[2], m_pl[2], m_cnt[2], m_err[2];
    int nn[2]  = '{2, 3};
    int cwm[2] = '{4, 256};

    mitll_andn_sync #(.N(2), .CW(2)) u_a (
        .clk(clk), .rst_n(rst_n), .in_tgl(in_tgl[1:0]), .ck_tgl(ck_tgl),
        .mode(mode), .err_clr(err_clr), .out_tgl(a_out), .out_pulse(a_pulse),
        .stored(a_st), .fire_cnt(a_cnt), .err_double(a_err)
    );

    mitll_andn_sync #(.N(3), .CW(8)) u_b (
        .clk(clk), .rst_n(rst_n), .in_tgl(in_tgl), .ck_tgl(ck_tgl),
        .mode(mode), .err_clr(err_clr), .out_tgl(b_out), .out_pulse(b_pulse),
        .stored(b_st), .fire_cnt(b_cnt), .err_double(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic [2:0] pm, input logic ckp, input logic [1:0] md,
                                input logic clr, input logic rst);
        for (int k = 0; k < 2; k++) begin
            int  n;
            int  msk;
            int  c;
            bit  ev;
            n   = nn[k];
            msk = int'(pm) & ((1 << n) - 1);
            if (!rst) begin
                m_st[k] = 0; m_out[k] = 0; m_pl[k] = 0; m_cnt[k] = 0; m_err[k] = 0;
            end else begin
                c  = $countones(m_st[k]);
                ev = 1'b0;
                if (ckp) begin
                    case (md)
                        2'd0:    ev = (c == n);
                        2'd1:    ev = (c > 0);
                        2'd2:    ev = (c % 2 == 1);
                        default: ev = (2 * c > n);
                    endcase
                    m_st[k] = msk;
                end else begin
                    if ((m_st[k] & msk) != 0) m_err[k] = 1;
                    m_st[k] = m_st[k] | msk;
                end
                if (clr) m_err[k] = 0;
                m_pl[k] = ev ? 1 : 0;
                if (ev) begin
                    m_out[k] = 1 - m_out[k];
                    m_cnt[k] = (m_cnt[k] + 1) % cwm[k];
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "/a.out_tgl"},   32'(a_out),   32'(m_out[0]));
        chk({tag, "/a.out_pulse"}, 32'(a_pulse), 32'(m_pl[0]));
        chk({tag, "/a.stored"},    32'(a_st),    32'(m_st[0]));
        chk({tag, "/a.fire_cnt"},  32'(a_cnt),   32'(m_cnt[0]));
        chk({tag, "/a.err"},       32'(a_err),   32'(m_err[0]));
        chk({tag, "/b.out_tgl"},   32'(b_out),   32'(m_out[1]));
        chk({tag, "/b.out_pulse"}, 32'(b_pulse), 32'(m_pl[1]));
        chk({tag, "/b.stored"},    32'(b_st),    32'(m_st[1]));
        chk({tag, "/b.fire_cnt"},  32'(b_cnt),   32'(m_cnt[1]));
        chk({tag, "/b.err"},       32'(b_err),   32'(m_err[1]));
    endtask

    // One cycle: apply pulses at the falling edge, check #1 after the rising edge
    task automatic step(input string tag, input logic [2:0] pm, input logic ckp,
                        input logic [1:0] md, input logic clr, input logic rst);
        @(negedge clk);
        in_tgl  = in_tgl ^ pm;
        ck_tgl  = ck_tgl ^ ckp;
        mode    = md;
        err_clr = clr;
        rst_n   = rst;
        model_update(pm, ckp, md, clr, rst);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        in_tgl  = 3'b000;
        ck_tgl  = 1'b0;
        mode    = 2'b00;
        err_clr = 1'b0;
        rst_n   = 1'b0;

        step("rst0", 3'b000, 1'b0, 2'd0, 1'b0, 1'b0);
        step("rst1", 3'b000, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("reset.out_tgl",  32'(a_out), 32'd0);
        chk("reset.fire_cnt", 32'(b_cnt), 32'd0);
        step("rel", 3'b000, 1'b0, 2'd0, 1'b0, 1'b1);

        // AND: a, b, a again (repeat flags error), then gate clock fires
        step("and_a",  3'b001, 1'b0, 2'd0, 1'b0, 1'b1);
        step("and_b",  3'b010, 1'b0, 2'd0, 1'b0, 1'b1);
        step("and_a2", 3'b001, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("and.err_set", 32'(a_err), 32'd1);
        step("and_ck", 3'b000, 1'b1, 2'd0, 1'b0, 1'b1);
        chk("and.out_tgl",  32'(a_out),   32'd1);
        chk("and.pulse",    32'(a_pulse), 32'd1);
        chk("and.fire_cnt", 32'(a_cnt),   32'd1);
        chk("and.stored",   32'(a_st),    32'd0);
        step("and_idle", 3'b000, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("and.pulse_drop", 32'(a_pulse), 32'd0);
        chk("and.err_sticky", 32'(a_err),   32'd1);
        step("clr", 3'b000, 1'b0, 2'd0, 1'b1, 1'b1);
        chk("clr.err", 32'(a_err), 32'd0);

        // AND with only b: no fire; then both fire
        step("andb_b",  3'b010, 1'b0, 2'd0, 1'b0, 1'b1);
        step("andb_ck", 3'b000, 1'b1, 2'd0, 1'b0, 1'b1);
        chk("andb.out_hold", 32'(a_out),   32'd1);
        chk("andb.no_pulse", 32'(a_pulse), 32'd0);
        chk("andb.stored",   32'(a_st),    32'd0);
        step("andab_ab", 3'b011, 1'b0, 2'd0, 1'b0, 1'b1);
        step("andab_ck", 3'b000, 1'b1, 2'd0, 1'b0, 1'b1);
        chk("andab.out_inv", 32'(a_out), 32'd0);

        // N=3 majority of inputs 0,2 then XOR of all three
        step("maj_in", 3'b101, 1'b0, 2'd3, 1'b0, 1'b1);
        step("maj_ck", 3'b000, 1'b1, 2'd3, 1'b0, 1'b1);
        chk("maj.pulse", 32'(b_pulse), 32'd1);
        step("xor_in", 3'b111, 1'b0, 2'd2, 1'b0, 1'b1);
        step("xor_ck", 3'b000, 1'b1, 2'd2, 1'b0, 1'b1);
        chk("xor.pulse", 32'(b_pulse), 32'd1);

        // OR with a data pulse coincident with the gate clock
        step("or_co", 3'b001, 1'b1, 2'd1, 1'b0, 1'b1);
        chk("or_co.no_fire", 32'(a_pulse), 32'd0);
        chk("or_co.stored",  32'(a_st),    32'd1);
        step("or_ck2", 3'b000, 1'b1, 2'd1, 1'b0, 1'b1);
        chk("or_ck2.fire", 32'(a_pulse), 32'd1);
        chk("or_ck2.err",  32'(a_err),   32'd0);

        // Mid-operation reset with input levels driven to 1
        step("rs_set", 3'b011, 1'b0, 2'd0, 1'b0, 1'b1);
        step("rs_low", ~in_tgl, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("rs.stored", 32'(b_st),  32'd0);
        chk("rs.out",    32'(a_out), 32'd0);
        step("rs_rel", 3'b000, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("rs_rel.stored", 32'(a_st),    32'd0);
        chk("rs_rel.pulse",  32'(a_pulse), 32'd0);
        step("rs_rel2", 3'b000, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("rs_rel2.stored", 32'(b_st), 32'd0);

        // CW=2 wrap: five firing evaluations
        for (int i = 0; i < 5; i++) begin
            logic [1:0] exp_cnt;
            exp_cnt = 2'(i + 1);
            step("wrap_in", 3'b001, 1'b0, 2'd1, 1'b0, 1'b1);
            step("wrap_ck", 3'b000, 1'b1, 2'd1, 1'b0, 1'b1);
            chk("wrap.fire_cnt", 32'(a_cnt), 32'(exp_cnt));
        end

        // Randomized traffic including back-to-back gate clocks and resets
        for (int i = 0; i < 600; i++) begin
            logic [2:0] pm;
            logic       ckp, clr, rst;
            logic [1:0] md;
            pm  = 3'($urandom);
            ckp = ($urandom_range(2) == 0);
            md  = 2'($urandom);
            clr = ($urandom_range(15) == 0);
            rst = !($urandom_range(80) == 0);
            step("rand", pm, ckp, md, clr, rst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mitll_andn_sync.md
MITLL_ANDN_SYNC -- requirements
Module: mitll_andn_sync

Purpose: synthesizable, parametrised successor of the two-input clocked RSFQ AND cell model. Handles N toggle-encoded data lines, a selectable gate function, flux-storage overflow detection and fire statistics. Everything runs on one digital sample clock.

Interface
REQ-001 Parameter N SHALL default to 2; it is the number of data inputs, legal range 1..16.
REQ-002 Parameter CW SHALL default to 8; it is the width of the fire counter, legal range 1..32.
REQ-003 clk  input  1  sample clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_tgl  input  N  toggle-encoded data pulses; any level change on bit i is one SFQ pulse on input i.
REQ-006 ck_tgl  input  1  toggle-encoded gate-clock pulse; any level change is one evaluation pulse.
REQ-007 mode  input  2  gate function: 00 AND, 01 OR, 10 XOR (odd count), 11 majority (count > N/2).
REQ-008 err_clr  input  1  synchronous clear of err_double.
REQ-009 out_tgl  output  1  toggle-encoded gate output.
REQ-010 out_pulse  output  1  one-cycle strobe, high in the same cycle that out_tgl changes.
REQ-011 stored  output  N  current stored-flux flags, one per input.
REQ-012 fire_cnt  output  CW  count of output pulses, wrapping.
REQ-013 err_double  output  1  sticky flag: a second pulse arrived on an input whose flag was already set.

Function
REQ-014 Pulse detection SHALL compare each input with its registered previous value, which updates every cycle; in_pX / ck_p denote a detected pulse in the current cycle.
REQ-015 A data pulse in_p[i] with no ck_p in the same cycle SHALL set stored[i] at the next edge.
REQ-016 A data pulse on an input already set SHALL leave stored[i] at 1 and set err_double; the second quantum is discarded.
REQ-017 On ck_p the gate SHALL evaluate mode applied to the stored flags as they were before that edge; a pulse arriving in the same cycle is excluded from this evaluation.
REQ-018 On ck_p all stored flags SHALL clear at the same edge.
REQ-019 A data pulse coincident with ck_p SHALL set its flag after the clear, so it is held for the next evaluation, and SHALL NOT set err_double.
REQ-020 If the evaluation is true, out_tgl SHALL invert and out_pulse SHALL be 1 for exactly the following cycle, i.e. one cycle of latency from the ck_tgl change.
REQ-021 If the evaluation is true, fire_cnt SHALL increment modulo 2^CW.
REQ-022 If the evaluation is false, out_tgl, out_pulse and fire_cnt SHALL remain unchanged, with out_pulse held at 0.
REQ-023 mode SHALL be sampled only in cycles where ck_p is detected; mode changes between clock pulses SHALL have no effect on the stored flags.
REQ-024 For N=1: AND, OR, XOR and majority SHALL all reduce to stored[0].
REQ-025 ck_p with all flags at 0 SHALL fire only if the selected function is true for a zero count; no mode meets this.
REQ-026 err_clr SHALL clear err_double, taking priority over a same-cycle set.
REQ-027 err_double SHALL otherwise remain set until reset.
REQ-028 Back-to-back ck_tgl changes on consecutive cycles SHALL each be evaluated independently.

Reset
REQ-029 While rst_n is low at a clk edge: stored=0, out_tgl=0, out_pulse=0, fire_cnt=0, err_double=0.
REQ-030 During reset, the previous-value registers SHALL load the current in_tgl and ck_tgl levels, so deassertion produces no spurious pulses.
REQ-031 Reset asserted mid-operation SHALL discard stored flux immediately, with no output pulse.

Verification
REQ-032 N=2, mode=00:
- Stimulus: toggle a, toggle b, toggle a again, then toggle ck.
- Response: a repeat sets err_double=1; on ck, out_tgl goes 0->1, out_pulse=1 for one cycle, fire_cnt=1, stored=00.
REQ-033 N=2, mode=00:
- Stimulus: toggle b only, then toggle ck.
- Response: no output change; stored=00 after ck.
- Follow-up: toggle a and b, toggle ck; out_tgl inverts.
REQ-034 N=3:
- Stimulus: mode=11 with pulses on inputs 0 and 2, then ck; mode=10 with pulses on inputs 0, 1 and 2, then ck.
- Response: the majority evaluation fires; the XOR evaluation fires (three pulses, odd count).
REQ-035 N=2, mode=01:
- Stimulus: in_tgl[0] and ck_tgl toggle in the same cycle; then toggle ck again.
- Response: no fire and stored=01 after the first ck; fire on the second ck; err_double stays 0.
REQ-036 CW=2:
- Stimulus: 5 firing evaluations.
- Response: fire_cnt sequence 1,2,3,0,1.
REQ-037 Reset case:
- Stimulus: set flags, pulse rst_n low for one cycle with in_tgl levels at 1, then release.
- Response: all outputs 0 and no spurious pulse after release.
